// File: rtl/faims_monitor.sv
// FAIMS drive-line monitor: measures period / HV pulse / coil work per FAIMS
// period and latches a sticky fault (with kill line) on illegal drive patterns.
`timescale 1ns/1ps

module faims_monitor #(
  parameter int CNT_W  = 11,
  parameter int WORK_W = 9
) (
  input  logic              CLK,
  input  logic              i_resetn,
  input  logic              i_enable,
  input  logic              i_faimsUp,
  input  logic              i_faimsDown,
  input  logic              i_coilAU,
  input  logic              i_coilAD,
  input  logic              i_coilBU,
  input  logic              i_coilBD,
  input  logic [7:0]        i_parMaxWork,
  input  logic              i_clearFault,
  output logic [CNT_W-1:0]  o_period,
  output logic [CNT_W-1:0]  o_pulseLen,
  output logic [WORK_W-1:0] o_workLen,
  output logic              o_valid,
  output logic              o_fault,
  output logic [2:0]        o_faultCode,
  output logic              o_kill
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WORK_W-1:0] WORK_MAX = '1;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} stateT;
  typedef enum logic [1:0] {PAIR_NONE = 2'd0, PAIR_A = 2'd1, PAIR_B = 2'd2} pairT;

  stateT             state, stateNext;
  logic              upPrev;
  logic [CNT_W-1:0]  periodCnt, pulseCnt;
  logic [WORK_W-1:0] workCnt;
  pairT              pairSeen, lastPair, curPair;

  logic       rise, pairA, pairB, coilActive, measuring, periodDone;
  logic [6:1] cause;
  logic [2:0] causeCode, codeNext;
  logic       faultNext;

  assign rise       = i_faimsUp & ~upPrev;
  assign pairA      = i_coilAU & i_coilBD;
  assign pairB      = i_coilAD & i_coilBU;
  assign coilActive = pairA | pairB;
  assign curPair    = pairA ? PAIR_A : (pairB ? PAIR_B : PAIR_NONE);
  assign measuring  = i_enable & (state == MEASURE);
  assign periodDone = measuring & rise;

  always_ff @(posedge CLK or negedge i_resetn) begin
    if (!i_resetn) state <= IDLE;
    else           state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (!i_enable)                     stateNext = IDLE;
    else if (state == IDLE && rise)    stateNext = MEASURE;
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    cause = '0;
    if (measuring) begin
      cause[1] = i_faimsUp & i_faimsDown;
      cause[2] = (i_coilAU & i_coilAD) | (i_coilBU & i_coilBD);
      cause[3] = (i_coilAU ^ i_coilBD) | (i_coilAD ^ i_coilBU);
      cause[4] = ~rise & coilActive & (workCnt >= WORK_W'(i_parMaxWork));
      cause[5] = rise ? (pairSeen != PAIR_NONE && pairSeen == lastPair)
                      : (curPair != PAIR_NONE && pairSeen != PAIR_NONE && curPair != pairSeen);
      cause[6] = (periodCnt == CNT_MAX);
    end

    // Scan high to low so the lowest active code is the one left standing.
    causeCode = '0;
    for (int k = 6; k >= 1; k--) begin
      if (cause[k]) causeCode = 3'(k);
    end

    faultNext = o_fault;
    codeNext  = o_faultCode;
    if (causeCode != 3'd0 && (!o_fault || i_clearFault)) begin
      faultNext = 1'b1;
      codeNext  = causeCode;
    end else if (i_clearFault && i_enable) begin
      faultNext = 1'b0;
      codeNext  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge i_resetn) begin
    if (!i_resetn) begin
      upPrev      <= 1'b0;
      periodCnt   <= '0;
      pulseCnt    <= '0;
      workCnt     <= '0;
      pairSeen    <= PAIR_NONE;
      lastPair    <= PAIR_NONE;
      o_period    <= '0;
      o_pulseLen  <= '0;
      o_workLen   <= '0;
      o_valid     <= 1'b0;
      o_fault     <= 1'b0;
      o_faultCode <= '0;
      o_kill      <= 1'b0;
    end else begin
      upPrev      <= i_faimsUp;
      o_valid     <= periodDone;
      o_fault     <= faultNext;
      o_faultCode <= codeNext;
      // Kill is a separate flop so the driver gating has its own register.
      o_kill      <= faultNext;

      if (periodDone) begin
        o_period   <= (periodCnt == CNT_MAX) ? CNT_MAX : periodCnt + CNT_W'(1);
        o_pulseLen <= pulseCnt;
        o_workLen  <= workCnt;
        lastPair   <= pairSeen;
      end

      if (!i_enable) begin
        periodCnt <= '0;
        pulseCnt  <= '0;
        workCnt   <= '0;
        pairSeen  <= PAIR_NONE;
      end else if (rise) begin
        // Covers both IDLE entry and a period boundary inside MEASURE.
        periodCnt <= '0;
        pulseCnt  <= CNT_W'(1);
        workCnt   <= '0;
        pairSeen  <= PAIR_NONE;
      end else if (state == MEASURE) begin
        if (periodCnt != CNT_MAX) periodCnt <= periodCnt + CNT_W'(1);
        if (i_faimsUp && pulseCnt != CNT_MAX) pulseCnt <= pulseCnt + CNT_W'(1);
        if (coilActive && workCnt != WORK_MAX) workCnt <= workCnt + WORK_W'(1);
        if (pairSeen == PAIR_NONE) pairSeen <= curPair;
      end
    end
  end

endmodule

// File: tb/tb_faims_monitor.sv
// Self-checking bench for faims_monitor: scoreboard of expected measurements
// popped on o_valid, plus per-scenario fault latch checks.
`timescale 1ns/1ps

module tb_faims_monitor;

  localparam int P_NONE = 0;
  localparam int P_A    = 1;
  localparam int P_B    = 2;

  logic        CLK = 1'b0;
  logic        i_resetn, i_enable, i_faimsUp, i_faimsDown;
  logic        i_coilAU, i_coilAD, i_coilBU, i_coilBD, i_clearFault;
  logic [7:0]  i_parMaxWork;
  logic [10:0] o_period, o_pulseLen;
  logic [8:0]  o_workLen;
  logic        o_valid, o_fault, o_kill;
  logic [2:0]  o_faultCode;

  typedef struct {
    int period;
    int pulse;
    int work;
  } measT;

  measT expQ[$];
  measT prevMeas;
  bit   havePrev;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  faims_monitor dut (
    .CLK(CLK), .i_resetn(i_resetn), .i_enable(i_enable),
    .i_faimsUp(i_faimsUp), .i_faimsDown(i_faimsDown),
    .i_coilAU(i_coilAU), .i_coilAD(i_coilAD), .i_coilBU(i_coilBU), .i_coilBD(i_coilBD),
    .i_parMaxWork(i_parMaxWork), .i_clearFault(i_clearFault),
    .o_period(o_period), .o_pulseLen(o_pulseLen), .o_workLen(o_workLen),
    .o_valid(o_valid), .o_fault(o_fault), .o_faultCode(o_faultCode), .o_kill(o_kill)
  );

  // Scoreboard consumer: every strobe must match the oldest expected measurement.
  always @(negedge CLK) begin
    measT e;
    if (o_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL valid_unexpected: strobe with period=%0d pulse=%0d work=%0d, required no strobe",
                 o_period, o_pulseLen, o_workLen);
      end else begin
        e = expQ.pop_front();
        if (o_period !== 11'(e.period) || o_pulseLen !== 11'(e.pulse) || o_workLen !== 9'(e.work)) begin
          errors++;
          $display("FAIL measurement: got period=%0d pulse=%0d work=%0d, required period=%0d pulse=%0d work=%0d",
                   o_period, o_pulseLen, o_workLen, e.period, e.pulse, e.work);
        end
      end
    end
  end

  task automatic drive_cycle(input logic up, dn, au, ad, bu, bd);
    @(posedge CLK);
    #1;
    i_faimsUp = up; i_faimsDown = dn;
    i_coilAU = au; i_coilAD = ad; i_coilBU = bu; i_coilBD = bd;
  endtask

  task automatic period_cycle(input int i, input int high, input int pair, input int cs, input int cl);
    logic act;
    act = (i >= cs) && (i < cs + cl);
    drive_cycle(i < high, 1'b0, act && pair == P_A, act && pair == P_B,
                act && pair == P_B, act && pair == P_A);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Drives one FAIMS period starting with its rise; the rise closes the previous
  // period, so that one's expected measurement is queued first.
  task automatic run_period(input int len, input int high, input int pair,
                            input int cs, input int cl, input int stopAt);
    if (havePrev) expQ.push_back(prevMeas);
    prevMeas = '{(len > 2047) ? 2047 : len, high, (pair == P_NONE) ? 0 : cl};
    havePrev = 1'b1;
    for (int i = 0; i < stopAt; i++) period_cycle(i, high, pair, cs, cl);
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    #1;
    i_resetn = 1'b0; i_enable = 1'b0; i_clearFault = 1'b0;
    i_faimsUp = 0; i_faimsDown = 0; i_coilAU = 0; i_coilAD = 0; i_coilBU = 0; i_coilBD = 0;
    i_parMaxWork = 8'd8;
    havePrev = 1'b0;
    repeat (3) @(posedge CLK);
    #1 i_resetn = 1'b1;
  endtask

  task automatic test_reset();
    i_resetn = 1'b0;
    #2;
    checks++;
    if ({o_period, o_pulseLen, o_workLen, o_valid, o_fault, o_faultCode, o_kill} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h, required 0",
               {o_period, o_pulseLen, o_workLen, o_valid, o_fault, o_faultCode, o_kill});
    end
    apply_reset();
    idle(2);
    checks++;
    if ({o_period, o_valid, o_fault, o_faultCode, o_kill} !== '0) begin
      errors++;
      $display("FAIL reset_release: period=%0d valid=%b fault=%b code=%0d kill=%b, required all 0",
               o_period, o_valid, o_fault, o_faultCode, o_kill);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    i_enable = 1'b1;
    for (int k = 0; k < 5; k++) run_period(10, 4, (k % 2) ? P_B : P_A, 5, 3, 10);
    run_period(10, 4, P_NONE, 0, 0, 2);
    idle(3);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL basic_strobes: %0d strobes missing, required 0", expQ.size());
    end
    checks++;
    if (o_period !== 11'd10 || o_pulseLen !== 11'd4 || o_workLen !== 9'd3) begin
      errors++;
      $display("FAIL basic_held: period=%0d pulse=%0d work=%0d, required 10/4/3", o_period, o_pulseLen, o_workLen);
    end
    checks++;
    if (o_fault !== 1'b0 || o_faultCode !== 3'd0 || o_kill !== 1'b0) begin
      errors++;
      $display("FAIL basic_nofault: fault=%b code=%0d kill=%b, required 0/0/0", o_fault, o_faultCode, o_kill);
    end
  endtask

  task automatic test_alternation();
    apply_reset();
    i_enable = 1'b1;
    run_period(10, 4, P_A, 5, 3, 10);
    run_period(10, 4, P_A, 5, 3, 10);
    run_period(10, 4, P_NONE, 0, 0, 1);
    checks++;
    if (o_fault !== 1'b0) begin
      errors++;
      $display("FAIL alt_early: fault=%b before repeated-pair rise, required 0", o_fault);
    end
    period_cycle(1, 4, P_NONE, 0, 0);
    checks++;
    if (o_fault !== 1'b1 || o_faultCode !== 3'd5 || o_kill !== 1'b1) begin
      errors++;
      $display("FAIL alt_latched: fault=%b code=%0d kill=%b, required 1/5/1", o_fault, o_faultCode, o_kill);
    end
    idle(2);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL alt_strobes: %0d strobes missing, required 0", expQ.size());
    end
  endtask

  task automatic test_priority();
    apply_reset();
    i_enable = 1'b1;
    run_period(10, 4, P_NONE, 0, 0, 2);
    drive_cycle(1, 1, 1, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_fault !== 1'b1 || o_faultCode !== 3'd1 || o_kill !== 1'b1) begin
      errors++;
      $display("FAIL prio_code1: fault=%b code=%0d kill=%b, required 1/1/1", o_fault, o_faultCode, o_kill);
    end
    idle(2100);
    checks++;
    if (o_faultCode !== 3'd1) begin
      errors++;
      $display("FAIL prio_sticky: code=%0d after timeout, required 1", o_faultCode);
    end
    // Clearing while the timeout cause is still present latches the new cause.
    i_clearFault = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 0);
    i_clearFault = 1'b0;
    checks++;
    if (o_fault !== 1'b1 || o_faultCode !== 3'd6) begin
      errors++;
      $display("FAIL prio_clear_relatch: fault=%b code=%0d, required 1/6", o_fault, o_faultCode);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      period_cycle(i, 4, P_NONE, 0, 0);
      if (i == 2040) begin
        checks++;
        if (o_fault !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: fault=%b at cycle %0d, required 0", o_fault, i);
        end
      end
      if (i == 2060) begin
        checks++;
        if (o_fault !== 1'b1 || o_faultCode !== 3'd6) begin
          errors++;
          $display("FAIL timeout_latched: fault=%b code=%0d, required 1/6", o_fault, o_faultCode);
        end
      end
    end
    expQ.push_back('{2047, 4, 0});
    drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    idle(2);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL timeout_saturated_strobe: %0d strobes missing, required 0", expQ.size());
    end
  endtask

  task automatic test_maxwork();
    apply_reset();
    i_parMaxWork = 8'd8;
    i_enable = 1'b1;
    run_period(20, 4, P_B, 2, 8, 20);
    expQ.push_back(prevMeas);
    havePrev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      period_cycle(i, 4, P_A, 2, 9);
      if (i == 1 || i == 10) begin
        checks++;
        if (o_fault !== 1'b0) begin
          errors++;
          $display("FAIL maxwork_early: fault=%b at cycle %0d, required 0", o_fault, i);
        end
      end
      if (i == 11) begin
        checks++;
        if (o_fault !== 1'b1 || o_faultCode !== 3'd4 || o_kill !== 1'b1) begin
          errors++;
          $display("FAIL maxwork_latched: fault=%b code=%0d kill=%b, required 1/4/1", o_fault, o_faultCode, o_kill);
        end
      end
      if (i == 16) begin
        i_clearFault = 1'b0;
        checks++;
        if (o_fault !== 1'b0 || o_faultCode !== 3'd0 || o_kill !== 1'b0) begin
          errors++;
          $display("FAIL maxwork_clear: fault=%b code=%0d kill=%b, required 0/0/0", o_fault, o_faultCode, o_kill);
        end
      end
      if (i == 15) i_clearFault = 1'b1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL maxwork_strobes: %0d strobes missing, required 0", expQ.size());
    end
  endtask

  task automatic test_enable();
    apply_reset();
    i_enable = 1'b1;
    run_period(10, 4, P_A, 5, 3, 10);
    run_period(10, 4, P_B, 5, 3, 5);
    i_enable = 1'b0;
    havePrev = 1'b0;
    idle(4);
    i_enable = 1'b1;
    run_period(12, 5, P_NONE, 0, 0, 12);
    checks++;
    if (o_period !== 11'd10 || o_pulseLen !== 11'd4 || o_workLen !== 9'd3) begin
      errors++;
      $display("FAIL enable_held: period=%0d pulse=%0d work=%0d, required 10/4/3", o_period, o_pulseLen, o_workLen);
    end
    run_period(12, 5, P_NONE, 0, 0, 2);
    idle(2);
    checks++;
    if (expQ.size() != 0 || o_period !== 11'd12) begin
      errors++;
      $display("FAIL enable_remeasure: outstanding=%0d period=%0d, required 0 and 12", expQ.size(), o_period);
    end
    checks++;
    if (o_fault !== 1'b0) begin
      errors++;
      $display("FAIL enable_nofault: fault=%b code=%0d, required 0", o_fault, o_faultCode);
    end
  endtask

  initial begin
    i_resetn = 1'b0; i_enable = 1'b0; i_clearFault = 1'b0;
    i_faimsUp = 0; i_faimsDown = 0; i_coilAU = 0; i_coilAD = 0; i_coilBU = 0; i_coilBD = 0;
    i_parMaxWork = 8'd8;
    havePrev = 1'b0;
    test_reset();
    test_basic();
    test_alternation();
    test_priority();
    test_timeout();
    test_maxwork();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
